telemetry_rcv: RTL and testbench
================================

TELEMETRY_RCV -- requirements
Module: telemetry_rcv

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per UART bit (50 MHz / 19200 baud).
REQ-002 clk  input  1  system clock; all state on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 RX  input  1  asynchronous serial line; idle high; 8N1, LSB first; carries the telemetry stream.
REQ-005 batt  output  12  last accepted battery reading.
REQ-006 curr  output  12  last accepted current reading.
REQ-007 torque  output  12  last accepted torque reading.
REQ-008 pkt_rdy  output  1  one-clock pulse; new batt/curr/torque valid.
REQ-009 pkt_err  output  1  one-clock pulse; packet discarded.

Function
REQ-010 RX shall pass through a 2-flop synchronizer preset to 1; only the synchronized value is used.
REQ-011 Byte receiver FSM shall have states IDLE, START, DATA, STOP.
REQ-012 IDLE -> START on synchronized RX low; baud counter loads BAUD_DIV/2.
REQ-013 START: at counter expiry, RX still low -> DATA with counter BAUD_DIV; RX high -> IDLE (false start, no byte, no error).
REQ-014 DATA: sample RX at each expiry (mid-bit), shift LSB first; after 8th sample -> STOP.
REQ-015 STOP: at expiry, RX high -> byte valid for exactly one clock, return to IDLE; RX low -> framing error, byte dropped, return to IDLE only once RX is high.
REQ-016 Packet format: 0xAA, 0x55, {4'h0,batt[11:8]}, batt[7:0], {4'h0,curr[11:8]}, curr[7:0], {4'h0,torque[11:8]}, torque[7:0].
REQ-017 Packet FSM states: HUNT_AA, HUNT_55, PAYLOAD; 3-bit payload index 0..5.
REQ-018 HUNT_AA: 0xAA -> HUNT_55; any other byte ignored.
REQ-019 HUNT_55: 0x55 -> PAYLOAD, index 0; 0xAA stays HUNT_55; other -> HUNT_AA; none of these raises pkt_err.
REQ-020 PAYLOAD: bytes at even index (0,2,4) with nonzero upper nibble -> pkt_err pulse, HUNT_AA.
REQ-021 Payload bytes shall be held in a shadow buffer; batt/curr/torque outputs shall not change until the packet is complete.
REQ-022 On valid byte at index 5: batt, curr, torque update from the shadow buffer, and pkt_rdy pulses, both on the clock after that byte's valid cycle; FSM -> HUNT_AA.
REQ-023 Framing error while in PAYLOAD -> pkt_err pulse, HUNT_AA; in HUNT states -> silently ignored.
REQ-024 pkt_rdy and pkt_err shall never assert in the same cycle; each is high for exactly one clock.
REQ-025 Outputs shall hold their values between packets; a discarded packet leaves them unchanged.
REQ-026 No timeout: an idle line mid-packet waits indefinitely.

Reset
REQ-027 rst_n low shall asynchronously force: byte FSM IDLE, packet FSM HUNT_AA, counters 0, synchronizer 1, batt/curr/torque 0, pkt_rdy/pkt_err 0.
REQ-028 Reset mid-byte or mid-packet discards partial data; the first packet accepted after release must begin with a fresh 0xAA.

Verification
REQ-029 Packet AA 55 0A 98 01 23 03 FF -> one pkt_rdy pulse; batt=0xA98, curr=0x123, torque=0x3FF; pkt_err never asserted.
REQ-030 Stream 12 AA AA 55 then payload 00 10 00 20 00 30 -> batt=0x010, curr=0x020, torque=0x030; exactly one pkt_rdy.
REQ-031 AA 55 0A 98 F1 23 .. -> pkt_err pulse on 5th byte; outputs keep prior values; next good packet accepted.
REQ-032 Byte 4 sent with stop bit 0 -> pkt_err pulse; outputs unchanged; receiver recovers on the following good packet.
REQ-033 RX low pulse of BAUD_DIV/4 clocks -> no byte, FSM back in IDLE, no pkt_err.
REQ-034 rst_n asserted after byte 5 of a packet, released, remaining bytes sent -> no pkt_rdy; outputs 0 until the next full packet.

Source files
------------

// File: rtl/telemetry_rcv.sv
// Telemetry UART receiver: 8N1 byte receiver feeding a framed packet decoder.
// Packet AA 55 then three 12-bit readings, each sent as a high byte then a low byte.
module telemetry_rcv #(
  parameter int BAUD_DIV = 2604
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        RX,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] torque,
  output logic        pkt_rdy,
  output logic        pkt_err
);

  localparam int CW = $clog2(BAUD_DIV + 1);
  localparam logic [CW-1:0] HALF = CW'(BAUD_DIV / 2);
  localparam logic [CW-1:0] FULL = CW'(BAUD_DIV);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} bstate_t;
  typedef enum logic [1:0] {HUNT_AA, HUNT_55, PAYLOAD} pstate_t;

  logic          r_rx_s1, r_rx_s2;
  logic          w_rx;
  bstate_t       r_bstate, w_bnext;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bitn, w_bitn_nxt;
  logic          r_fwait, w_fwait_nxt;
  logic [7:0]    r_shreg;
  logic          w_exp, w_shift, w_bvld, w_ferr;

  pstate_t       r_pstate, w_pnext;
  logic [2:0]    r_idx, w_idx_nxt;
  logic          w_store, w_commit, w_perr;
  logic [11:0]   r_sh_b, r_sh_c;
  logic [3:0]    r_sh_t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_s1 <= 1'b1;
      r_rx_s2 <= 1'b1;
    end else begin
      r_rx_s1 <= RX;
      r_rx_s2 <= r_rx_s1;
    end
  end

  assign w_rx  = r_rx_s2;
  assign w_exp = (r_cnt == CW'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bstate <= IDLE;
      r_cnt    <= '0;
      r_bitn   <= '0;
      r_fwait  <= 1'b0;
      r_shreg  <= '0;
    end else begin
      r_bstate <= w_bnext;
      r_cnt    <= w_cnt_nxt;
      r_bitn   <= w_bitn_nxt;
      r_fwait  <= w_fwait_nxt;
      if (w_shift) r_shreg <= {w_rx, r_shreg[7:1]};
    end
  end

  always_comb begin
    w_bnext     = r_bstate;
    w_cnt_nxt   = (r_cnt != '0) ? r_cnt - CW'(1) : '0;
    w_bitn_nxt  = r_bitn;
    w_fwait_nxt = r_fwait;
    w_shift     = 1'b0;
    w_bvld      = 1'b0;
    w_ferr      = 1'b0;
    unique case (r_bstate)
      IDLE: begin
        if (!w_rx) begin
          w_bnext   = START;
          w_cnt_nxt = HALF;
        end
      end
      START: begin
        if (w_exp) begin
          if (!w_rx) begin
            w_bnext    = DATA;
            w_cnt_nxt  = FULL;
            w_bitn_nxt = '0;
          end else begin
            w_bnext = IDLE;
          end
        end
      end
      DATA: begin
        if (w_exp) begin
          w_shift    = 1'b1;
          w_cnt_nxt  = FULL;
          w_bitn_nxt = r_bitn + 3'd1;
          if (r_bitn == 3'd7) w_bnext = STOP;
        end
      end
      STOP: begin
        // After a bad stop bit, hold here until the line returns high
        if (r_fwait) begin
          if (w_rx) begin
            w_bnext     = IDLE;
            w_fwait_nxt = 1'b0;
          end
        end else if (w_exp) begin
          if (w_rx) begin
            w_bvld  = 1'b1;
            w_bnext = IDLE;
          end else begin
            w_ferr      = 1'b1;
            w_fwait_nxt = 1'b1;
          end
        end
      end
      default: w_bnext = IDLE;
    endcase
  end

  always_comb begin
    w_pnext   = r_pstate;
    w_idx_nxt = r_idx;
    w_store   = 1'b0;
    w_commit  = 1'b0;
    w_perr    = 1'b0;
    unique case (r_pstate)
      HUNT_AA: begin
        if (w_bvld && r_shreg == 8'hAA) w_pnext = HUNT_55;
      end
      HUNT_55: begin
        if (w_bvld) begin
          if (r_shreg == 8'h55) begin
            w_pnext   = PAYLOAD;
            w_idx_nxt = '0;
          end else if (r_shreg != 8'hAA) begin
            w_pnext = HUNT_AA;
          end
        end
      end
      PAYLOAD: begin
        if (w_ferr) begin
          w_perr  = 1'b1;
          w_pnext = HUNT_AA;
        end else if (w_bvld) begin
          if (!r_idx[0] && r_shreg[7:4] != 4'h0) begin
            w_perr  = 1'b1;
            w_pnext = HUNT_AA;
          end else if (r_idx == 3'd5) begin
            w_commit = 1'b1;
            w_pnext  = HUNT_AA;
          end else begin
            w_store   = 1'b1;
            w_idx_nxt = r_idx + 3'd1;
          end
        end
      end
      default: w_pnext = HUNT_AA;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pstate <= HUNT_AA;
      r_idx    <= '0;
      r_sh_b   <= '0;
      r_sh_c   <= '0;
      r_sh_t   <= '0;
      batt     <= '0;
      curr     <= '0;
      torque   <= '0;
      pkt_rdy  <= 1'b0;
      pkt_err  <= 1'b0;
    end else begin
      r_pstate <= w_pnext;
      r_idx    <= w_idx_nxt;
      pkt_rdy  <= w_commit;
      pkt_err  <= w_perr;
      if (w_store) begin
        unique case (r_idx)
          3'd0:    r_sh_b[11:8] <= r_shreg[3:0];
          3'd1:    r_sh_b[7:0]  <= r_shreg;
          3'd2:    r_sh_c[11:8] <= r_shreg[3:0];
          3'd3:    r_sh_c[7:0]  <= r_shreg;
          default: r_sh_t       <= r_shreg[3:0];
        endcase
      end
      // Readings only become visible once the whole packet has arrived
      if (w_commit) begin
        batt   <= r_sh_b;
        curr   <= r_sh_c;
        torque <= {r_sh_t, r_shreg};
      end
    end
  end

endmodule

// File: tb/tb_telemetry_rcv.sv
// Directed bench for telemetry_rcv: table of byte streams with expected
// readings and pulse counts, plus hand sequences for framing, glitch, reset.
module tb_telemetry_rcv;

  localparam int BD = 16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        RX = 1'b1;
  logic [11:0] batt, curr, torque;
  logic        pkt_rdy, pkt_err;

  telemetry_rcv #(.BAUD_DIV(BD)) dut (
    .clk(clk), .rst_n(rst_n), .RX(RX),
    .batt(batt), .curr(curr), .torque(torque),
    .pkt_rdy(pkt_rdy), .pkt_err(pkt_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int                n;
    logic [0:9][7:0]   bs;
    logic [11:0]       eb, ec, et;
    int                er, ee;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int n_rdy = 0;
  int n_err = 0;
  int mon_bad = 0;
  logic prev_rdy = 1'b0;
  logic prev_err = 1'b0;
  logic [35:0] prev_out = '0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (pkt_rdy) n_rdy++;
      if (pkt_err) n_err++;
      if (pkt_rdy && pkt_err) mon_bad++;
      if ((pkt_rdy && prev_rdy) || (pkt_err && prev_err)) mon_bad++;
      if (!pkt_rdy && {batt, curr, torque} != prev_out) mon_bad++;
    end
    prev_rdy = pkt_rdy;
    prev_err = pkt_err;
    prev_out = {batt, curr, torque};
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stopb);
    RX = 1'b0;
    tick(BD);
    for (int i = 0; i < 8; i++) begin
      RX = b[i];
      tick(BD);
    end
    RX = stopb;
    tick(BD);
    RX = 1'b1;
    if (!stopb) tick(BD);
  endtask

  task automatic send_seq(input logic [0:9][7:0] bs, input int n);
    for (int i = 0; i < n; i++) send_byte(bs[i], 1'b1);
  endtask

  task automatic chk_out(input string nm, input logic [11:0] b,
                         input logic [11:0] c, input logic [11:0] t);
    chk({nm, ".batt"}, int'(batt), int'(b));
    chk({nm, ".curr"}, int'(curr), int'(c));
    chk({nm, ".torque"}, int'(torque), int'(t));
  endtask

  vec_t vt[8];
  int   br, be;

  initial begin
    vt[0] = '{8, {8'hAA,8'h55,8'h0A,8'h98,8'h01,8'h23,8'h03,8'hFF,8'h00,8'h00},
              12'hA98, 12'h123, 12'h3FF, 1, 0};
    vt[1] = '{8, {8'hAA,8'h55,8'h0A,8'h98,8'hF1,8'h23,8'h00,8'h00,8'h00,8'h00},
              12'hA98, 12'h123, 12'h3FF, 0, 1};
    vt[2] = '{10, {8'h12,8'hAA,8'hAA,8'h55,8'h00,8'h10,8'h00,8'h20,8'h00,8'h30},
              12'h010, 12'h020, 12'h030, 1, 0};
    vt[3] = '{8, {8'hAA,8'h55,8'h01,8'h00,8'h02,8'h00,8'h13,8'h00,8'h00,8'h00},
              12'h010, 12'h020, 12'h030, 0, 1};
    vt[4] = '{10, {8'hAA,8'h12,8'hAA,8'h55,8'h0B,8'hBB,8'h0C,8'hCC,8'h0D,8'hDD},
              12'hBBB, 12'hCCC, 12'hDDD, 1, 0};
    vt[5] = '{8, {8'hAA,8'h55,8'h0F,8'hFF,8'h0F,8'hFF,8'h0F,8'hFF,8'h00,8'h00},
              12'hFFF, 12'hFFF, 12'hFFF, 1, 0};
    vt[6] = '{8, {8'hAA,8'h55,8'h55,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
              12'hFFF, 12'hFFF, 12'hFFF, 0, 1};
    vt[7] = '{8, {8'hAA,8'h55,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00},
              12'h000, 12'h000, 12'h000, 1, 0};

    tick(4);
    chk_out("reset", 12'h0, 12'h0, 12'h0);
    chk("reset.rdy", int'(pkt_rdy), 0);
    chk("reset.err", int'(pkt_err), 0);
    rst_n = 1'b1;
    tick(2 * BD);

    for (int v = 0; v < 8; v++) begin
      br = n_rdy;
      be = n_err;
      send_seq(vt[v].bs, vt[v].n);
      tick(2 * BD);
      chk_out($sformatf("vec%0d", v), vt[v].eb, vt[v].ec, vt[v].et);
      chk($sformatf("vec%0d.rdy", v), n_rdy - br, vt[v].er);
      chk($sformatf("vec%0d.err", v), n_err - be, vt[v].ee);
    end

    br = n_rdy;
    be = n_err;
    send_byte(8'hAA, 1'b1);
    send_byte(8'h55, 1'b1);
    send_byte(8'h0A, 1'b1);
    send_byte(8'h98, 1'b0);
    tick(3 * BD);
    chk("frm.err", n_err - be, 1);
    chk("frm.rdy", n_rdy - br, 0);
    chk_out("frm", 12'h000, 12'h000, 12'h000);
    br = n_rdy;
    send_seq({8'hAA,8'h55,8'h04,8'h56,8'h07,8'h89,8'h0A,8'hBC,8'h00,8'h00}, 8);
    tick(2 * BD);
    chk("frm_rec.rdy", n_rdy - br, 1);
    chk_out("frm_rec", 12'h456, 12'h789, 12'hABC);

    br = n_rdy;
    be = n_err;
    send_seq({8'hAA,8'h55,8'h0A,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3);
    RX = 1'b0;
    tick(BD / 4);
    RX = 1'b1;
    tick(2 * BD);
    send_seq({8'h98,8'h01,8'h23,8'h03,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00}, 5);
    tick(2 * BD);
    chk("glitch.rdy", n_rdy - br, 1);
    chk("glitch.err", n_err - be, 0);
    chk_out("glitch", 12'hA98, 12'h123, 12'h3FF);

    br = n_rdy;
    be = n_err;
    send_seq({8'hAA,8'h55,8'h0A,8'h98,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00}, 5);
    rst_n = 1'b0;
    tick(3);
    chk_out("in_rst", 12'h0, 12'h0, 12'h0);
    rst_n = 1'b1;
    tick(BD);
    send_seq({8'h23,8'h03,8'hFF,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, 3);
    tick(2 * BD);
    chk("rst.rdy", n_rdy - br, 0);
    chk("rst.err", n_err - be, 0);
    chk_out("rst", 12'h0, 12'h0, 12'h0);
    send_seq({8'hAA,8'h55,8'h01,8'h11,8'h02,8'h22,8'h03,8'h33,8'h00,8'h00}, 8);
    tick(2 * BD);
    chk("rst_rec.rdy", n_rdy - br, 1);
    chk_out("rst_rec", 12'h111, 12'h222, 12'h333);

    chk("monitor", mon_bad, 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
